jk_counter_ctrl: RTL and testbench
==================================

// Module: jk_counter_ctrl
// PURPOSE
//  Sequencer for an external bank of WIDTH JK flip-flops, wired as a mod-MODULUS counter.
//  Accepts LOAD/RUN/STOP commands over a valid/ready handshake.
//  Drives per-bit J/K excitation from the bank's Q feedback, so the bank steps one count per clock.
//  Counts run-length steps and flags terminal count (wrap).
//  Sits between the control/test logic and the flip-flop datapath in the counter subsystem.
// PARAMETERS
//  WIDTH    4   bits in the flip-flop bank
//  MODULUS  10  count wraps MODULUS-1 -> 0 (up); requires 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk        in   1      clock; bank shares the same posedge
//  rst        in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      command accepted when cmd_valid & cmd_ready at posedge
//  cmd_op     in   2      00 NOP, 01 LOAD, 10 RUN, 11 STOP
//  cmd_data   in   WIDTH  LOAD: target value; RUN: number of steps (0 = free-run)
//  cmd_dir    in   1      RUN direction, 0 up / 1 down (ignored without JKC_DOWN_EN)
//  q          in   WIDTH  Q feedback from the flip-flop bank
//  j, k       out  WIDTH  per-bit J/K to the bank
//  busy       out  1      state != IDLE
//  tc         out  1      one-cycle pulse on wrap
//  done       out  1      one-cycle pulse when a finite RUN or a LOAD completes
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, step_cnt=0, dir=0; tc=done=0, cmd_ready=1.
//   j=k=0 while rst is low (bank holds).
//  j/k are combinational from registered state and q. IDLE drives j=k=0 (hold).
//  Excitation per bit, nq = target: q=0 -> j=nq, k=0; q=1 -> j=0, k=~nq.
//   Never emits 11 (toggle); excitation is always explicit set/reset/hold.
//  FSM:
//   IDLE: cmd_ready=1.
//    LOAD -> LOAD_S, latch cmd_data.
//    RUN -> RUN_S, latch step_cnt=cmd_data and dir.
//    STOP or NOP -> stay in IDLE.
//   LOAD_S: one cycle; j/k target = latched value (mod MODULUS if >= MODULUS).
//    -> IDLE with done=1 next cycle. cmd_ready=0.
//   RUN_S: target = q+1 (up), q-1 (down); up wraps MODULUS-1 -> 0, down wraps 0 -> MODULUS-1.
//    tc is registered: it pulses in the cycle after the wrap-producing edge.
//    If step_cnt != 0: decrement per clock; on the edge where 1 -> 0, go to IDLE with done=1.
//     Exactly N steps for N.
//    step_cnt = 0 at entry: free-run until STOP; no done pulse.
//    cmd_ready=1 in RUN_S, but only STOP is acted on.
//     STOP -> IDLE next edge; that same edge still steps the bank; no done pulse.
//     Other ops are accepted and dropped.
//  q >= MODULUS in RUN_S (illegal): target = 0; tc not asserted.
//  Reset mid-operation: immediate IDLE; any pending count is lost.
//  Simultaneous final step + STOP: finish with done=1 (step completes first).
// CONFIGURATION
//  JKC_DOWN_EN defined: cmd_dir honoured; down counting as above.
//  JKC_DOWN_EN undefined: dir forced 0; cmd_dir unused; down logic removed.
// STRUCTURE
//  Shared package jkc_pkg:
//   jkc_op_t enum (NOP/LOAD/RUN/STOP)
//   jkc_state_t enum (IDLE/LOAD_S/RUN_S)
//   JKC_OP_W = 2
//  Sub-module jk_excite: combinational (q, target) -> (j, k), WIDTH-parameterised.
//  Bench instantiates the flip-flop bank and closes the q loop.
// TESTING
//  1. Reset: rst=0 with q=4'h7 -> j=k=0, busy=0, cmd_ready=1; release -> outputs unchanged.
//  2. LOAD 4'd6 from q=0 -> j=4'b0110, k=0; next edge q=6; done pulses once; busy=0.
//  3. RUN N=3 from q=8, MODULUS=10 -> q 9,0,1 on successive edges.
//     tc pulses in the cycle after the 9->0 edge; done after the third step.
//  4. RUN N=0 (free-run), STOP after 5 cycles -> q advanced exactly 6; no done; IDLE; j=k=0.
//  5. JKC_DOWN_EN, RUN dir=1 N=2 from q=1 -> q 0, 9; tc pulses in the cycle after the 0->9 edge.
//  6. rst low mid-RUN at q=3 -> IDLE immediately, j=k=0, q held at 3; LOAD afterwards works.

Source files
------------

// File: rtl/jkc_pkg.sv
// Shared types for the JK counter sequencer: command opcodes, FSM states, opcode width.
package jkc_pkg;

    localparam int JKC_OP_W = 2;

    typedef enum logic [JKC_OP_W-1:0] {
        NOP  = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        STOP = 2'b11
    } jkc_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_S = 2'd1,
        RUN_S  = 2'd2
    } jkc_state_t;

endpackage

// File: rtl/jk_counter_ctrl_if.sv
// Command channel (valid/ready handshake) between control/test logic and the JK sequencer.
interface jk_counter_ctrl_if #(
    parameter int WIDTH = 4
);
    import jkc_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    jkc_op_t          cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_dir,
        output cmd_ready
    );

endinterface

// File: rtl/jk_excite.sv
// Per-bit JK excitation from present state q to next state nq; only set/reset/hold, never toggle.
module jk_excite #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] nq,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    assign j = ~q & nq;
    assign k = q & ~nq;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Sequencer for an external JK flip-flop bank wired as a mod-MODULUS counter.
// Optional down counting is enabled by defining JKC_DOWN_EN.
module jk_counter_ctrl
    import jkc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic              clk,
    input  logic              rst,
    jk_counter_ctrl_if.slave  cmd,
    input  logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  j,
    output logic [WIDTH-1:0]  k,
    output logic              busy,
    output logic              tc,
    output logic              done
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

    jkc_state_t       state;
    logic [WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] j_x;
    logic [WIDTH-1:0] k_x;
    logic             wrap;
    logic             q_legal;
    logic             accept;

`ifdef JKC_DOWN_EN
    logic dir;
`else
    logic unused_dir;
    assign unused_dir = cmd.cmd_dir;
`endif

    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] v);
        return ({1'b0, v} >= MOD_EXT) ? WIDTH'({1'b0, v} % MOD_EXT) : v;
    endfunction

    function automatic logic [WIDTH-1:0] next_up(input logic [WIDTH-1:0] v);
        return (v == TOP) ? '0 : v + 1'b1;
    endfunction

`ifdef JKC_DOWN_EN
    function automatic logic [WIDTH-1:0] next_down(input logic [WIDTH-1:0] v);
        return (v == '0) ? TOP : v - 1'b1;
    endfunction
`endif

    assign accept  = cmd.cmd_valid & cmd.cmd_ready;
    assign q_legal = ({1'b0, q} < MOD_EXT);

    // Out-of-range bank state is steered to 0 and never counts as a wrap.
    always_comb begin
        nq   = '0;
        wrap = 1'b0;
        case (state)
            LOAD_S: nq = fold(load_val);
            RUN_S: begin
                if (q_legal) begin
`ifdef JKC_DOWN_EN
                    if (dir) begin
                        nq   = next_down(q);
                        wrap = (q == '0);
                    end else
`endif
                    begin
                        nq   = next_up(q);
                        wrap = (q == TOP);
                    end
                end
            end
            default: nq = '0;
        endcase
    end

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .q  (q),
        .nq (nq),
        .j  (j_x),
        .k  (k_x)
    );

    assign j = (state == IDLE) ? '0 : j_x;
    assign k = (state == IDLE) ? '0 : k_x;

    // Latched LOAD target is datapath only and needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept && cmd.cmd_op == LOAD)
            load_val <= cmd.cmd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            step_cnt      <= '0;
            tc            <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b1;
`ifdef JKC_DOWN_EN
            dir           <= 1'b0;
`endif
        end else begin
            tc   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && cmd.cmd_op == LOAD) begin
                        state         <= LOAD_S;
                        busy          <= 1'b1;
                        cmd.cmd_ready <= 1'b0;
                    end else if (accept && cmd.cmd_op == RUN) begin
                        state    <= RUN_S;
                        busy     <= 1'b1;
                        step_cnt <= cmd.cmd_data;
`ifdef JKC_DOWN_EN
                        dir      <= cmd.cmd_dir;
`endif
                    end
                end
                LOAD_S: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    cmd.cmd_ready <= 1'b1;
                end
                RUN_S: begin
                    tc <= wrap;
                    // Final step wins over a coincident STOP so the run still reports done.
                    if (step_cnt == WIDTH'(1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        step_cnt <= '0;
                    end else if (accept && cmd.cmd_op == STOP) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        step_cnt <= '0;
                    end else if (step_cnt != '0) begin
                        step_cnt <= step_cnt - 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    cmd.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Directed bench for jk_counter_ctrl with a behavioural JK flip-flop bank closing the q loop.
module tb_jk_counter_ctrl;
    import jkc_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] q;
    logic [3:0] j;
    logic [3:0] k;
    logic       busy;
    logic       tc;
    logic       done;
    logic       bank_set;
    logic [3:0] bank_val;
    int         checks;
    int         failures;

    jk_counter_ctrl_if #(.WIDTH(4)) cmd_bus ();

    jk_counter_ctrl #(.WIDTH(4), .MODULUS(10)) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd_bus),
        .q    (q),
        .j    (j),
        .k    (k),
        .busy (busy),
        .tc   (tc),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // JK bank: Q+ = J~Q | ~KQ, with a bench-side preset for arbitrary start states.
    always @(posedge clk) begin
        if (bank_set) q <= bank_val;
        else          q <= (j & ~q) | (~k & q);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input jkc_op_t op, input logic [3:0] data, input logic dir);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_data  = data;
        cmd_bus.cmd_dir   = dir;
        tick();
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = NOP;
        cmd_bus.cmd_data  = 4'd0;
        cmd_bus.cmd_dir   = 1'b0;
    endtask

    task automatic preset(input logic [3:0] v);
        bank_set = 1'b1;
        bank_val = v;
        tick();
        bank_set = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b0;
        bank_set          = 1'b0;
        bank_val          = 4'd0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = NOP;
        cmd_bus.cmd_data  = 4'd0;
        cmd_bus.cmd_dir   = 1'b0;

        // Reset with the bank sitting at 7
        preset(4'h7);
        chk("rst_j",     32'(j), 32'd0);
        chk("rst_k",     32'(k), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        chk("rst_tc",    32'(tc), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rel_q",     32'(q), 32'd7);
        chk("rel_j",     32'(j), 32'd0);
        chk("rel_k",     32'(k), 32'd0);
        chk("rel_busy",  32'(busy), 32'd0);
        chk("rel_ready", 32'(cmd_bus.cmd_ready), 32'd1);

        // LOAD 6 from q=0
        preset(4'h0);
        send(LOAD, 4'd6, 1'b0);
        chk("ld6_j",     32'(j), 32'h6);
        chk("ld6_k",     32'(k), 32'h0);
        chk("ld6_busy",  32'(busy), 32'd1);
        chk("ld6_ready", 32'(cmd_bus.cmd_ready), 32'd0);
        tick();
        chk("ld6_q",     32'(q), 32'd6);
        chk("ld6_done",  32'(done), 32'd1);
        chk("ld6_idle",  32'(busy), 32'd0);
        tick();
        chk("ld6_done0", 32'(done), 32'd0);

        // LOAD 13 folds to 3: from q=6, j=0001 k=0100
        send(LOAD, 4'd13, 1'b0);
        chk("ld13_j",    32'(j), 32'h1);
        chk("ld13_k",    32'(k), 32'h4);
        tick();
        chk("ld13_q",    32'(q), 32'd3);

        // RUN 3 up from 8: 9, 0, 1
        send(LOAD, 4'd8, 1'b0);
        tick();
        chk("r3_q8",     32'(q), 32'd8);
        send(RUN, 4'd3, 1'b0);
        chk("r3_busy",   32'(busy), 32'd1);
        chk("r3_j",      32'(j), 32'h1);
        chk("r3_k",      32'(k), 32'h0);
        tick();
        chk("r3_q9",     32'(q), 32'd9);
        chk("r3_tc_a",   32'(tc), 32'd0);
        tick();
        chk("r3_q0",     32'(q), 32'd0);
        chk("r3_tc",     32'(tc), 32'd1);
        chk("r3_done_a", 32'(done), 32'd0);
        tick();
        chk("r3_q1",     32'(q), 32'd1);
        chk("r3_tc_b",   32'(tc), 32'd0);
        chk("r3_done",   32'(done), 32'd1);
        chk("r3_idle",   32'(busy), 32'd0);
        tick();
        chk("r3_hold",   32'(q), 32'd1);
        chk("r3_done0",  32'(done), 32'd0);

        // Free run from 1, a dropped LOAD midway, STOP after 5 cycles
        send(RUN, 4'd0, 1'b0);
        tick();
        tick();
        send(LOAD, 4'd2, 1'b0);
        chk("fr_q4",     32'(q), 32'd4);
        chk("fr_busy",   32'(busy), 32'd1);
        chk("fr_ready",  32'(cmd_bus.cmd_ready), 32'd1);
        tick();
        tick();
        chk("fr_q6",     32'(q), 32'd6);
        send(STOP, 4'd0, 1'b0);
        chk("fr_q7",     32'(q), 32'd7);
        chk("fr_idle",   32'(busy), 32'd0);
        chk("fr_done",   32'(done), 32'd0);
        chk("fr_j",      32'(j), 32'd0);
        chk("fr_k",      32'(k), 32'd0);
        tick();
        chk("fr_hold",   32'(q), 32'd7);
        chk("fr_done_b", 32'(done), 32'd0);

        // Final step coincident with STOP still reports done
        send(RUN, 4'd1, 1'b0);
        send(STOP, 4'd0, 1'b0);
        chk("fs_q",      32'(q), 32'd8);
        chk("fs_done",   32'(done), 32'd1);
        chk("fs_idle",   32'(busy), 32'd0);

        // Illegal bank state 12 in RUN: steered to 0 with no tc
        preset(4'd12);
        send(RUN, 4'd1, 1'b0);
        chk("il_j",      32'(j), 32'h0);
        chk("il_k",      32'(k), 32'hc);
        tick();
        chk("il_q",      32'(q), 32'd0);
        chk("il_tc",     32'(tc), 32'd0);
        chk("il_done",   32'(done), 32'd1);

        // Reset in the middle of a RUN at q=3
        send(RUN, 4'd8, 1'b0);
        tick();
        tick();
        tick();
        chk("mr_q3",     32'(q), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_busy",   32'(busy), 32'd0);
        chk("mr_j",      32'(j), 32'd0);
        chk("mr_k",      32'(k), 32'd0);
        chk("mr_ready",  32'(cmd_bus.cmd_ready), 32'd1);
        tick();
        chk("mr_hold",   32'(q), 32'd3);
        rst = 1'b1;
        tick();
        send(LOAD, 4'd5, 1'b0);
        chk("mr_ldbusy", 32'(busy), 32'd1);
        tick();
        chk("mr_ldq",    32'(q), 32'd5);
        chk("mr_lddone", 32'(done), 32'd1);

`ifdef JKC_DOWN_EN
        // Down count from 1: 0, 9 with tc after the 0->9 edge
        send(LOAD, 4'd1, 1'b0);
        tick();
        send(RUN, 4'd2, 1'b1);
        tick();
        chk("dn_q0",     32'(q), 32'd0);
        chk("dn_tc_a",   32'(tc), 32'd0);
        tick();
        chk("dn_q9",     32'(q), 32'd9);
        chk("dn_tc",     32'(tc), 32'd1);
        chk("dn_done",   32'(done), 32'd1);
        tick();
        chk("dn_tc0",    32'(tc), 32'd0);
`else
        // Direction request is ignored: still counts up from 5
        send(RUN, 4'd1, 1'b1);
        tick();
        chk("nd_q",      32'(q), 32'd6);
        chk("nd_done",   32'(done), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
